// File: rtl/id_pkg.sv
// Shared types and sizing helpers for the ID-stage operand scoreboard.
// The entry record is sized for the widest register index any instance may use.
package id_pkg;

  localparam int DEF_REG_W = 5;
  localparam int MAX_REG_W = 8;
  localparam int CNT_W     = 8;

  typedef struct packed {
    logic                 valid;
    logic [MAX_REG_W-1:0] idx;
    logic [CNT_W-1:0]     wait_cnt;
  } entry_t;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/scoreboard_lookup.sv
// Per-source lookup: finds the youngest in-flight writer of src and reports
// whether its value is already forwardable or still pending.
module scoreboard_lookup
  import id_pkg::*;
#(
  parameter int FWD_DEPTH = 2,
  parameter int REG_W     = DEF_REG_W,
  parameter int SEL_W     = 2
) (
  input  entry_t [FWD_DEPTH-1:0] ents,
  input  logic   [REG_W-1:0]     src,
  input  logic                   used,
  output logic   [SEL_W-1:0]     sel,
  output logic                   pending
);

  logic hit;

  // Scan from stage 1 outward; the first hit is the youngest writer.
  always_comb begin
    sel     = '0;
    pending = 1'b0;
    hit     = 1'b0;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      if (!hit && used && (src != '0) && ents[k].valid &&
          (ents[k].idx == MAX_REG_W'(src))) begin
        hit = 1'b1;
        if (ents[k].wait_cnt != '0) pending = 1'b1;
        else                        sel     = SEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/id_scoreboard.sv
// ID-stage scoreboard: tracks destinations of in-flight instructions, selects
// forwarding sources and raises a load-use stall.
module id_scoreboard
  import id_pkg::*;
#(
  parameter  int NUM_SRC   = 2,
  parameter  int FWD_DEPTH = 2,
  parameter  int LOAD_LAT  = 1,
  parameter  int REG_W     = DEF_REG_W,
  localparam int SEL_W     = sel_w(FWD_DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [NUM_SRC*REG_W-1:0] src_reg,
  input  logic [NUM_SRC-1:0]       src_used,
  input  logic [REG_W-1:0]         dst_reg,
  input  logic                     dst_we,
  input  logic                     dst_is_load,
  input  logic                     flush,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic                     stall,
  output logic [15:0]              stall_count
);

  if (LOAD_LAT < 0 || LOAD_LAT > FWD_DEPTH - 1) begin : g_bad_lat
    $error("id_scoreboard: LOAD_LAT must lie in 0..FWD_DEPTH-1");
  end
  if (REG_W > MAX_REG_W || REG_W < 1) begin : g_bad_reg_w
    $error("id_scoreboard: REG_W out of range for entry_t");
  end

  entry_t [FWD_DEPTH-1:0] ents;
  entry_t                 new_ent;
  logic   [NUM_SRC-1:0]   pend;
  logic                   accept;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    scoreboard_lookup #(
      .FWD_DEPTH (FWD_DEPTH),
      .REG_W     (REG_W),
      .SEL_W     (SEL_W)
    ) u_lookup (
      .ents    (ents),
      .src     (src_reg[i*REG_W +: REG_W]),
      .used    (src_used[i]),
      .sel     (fwd_sel[i*SEL_W +: SEL_W]),
      .pending (pend[i])
    );
  end

  assign stall       = issue_valid & ~flush & (|pend);
  assign issue_ready = ~stall;
  assign accept      = issue_valid & issue_ready & ~flush & dst_we & (dst_reg != '0);

  // Writes to r0 never enter the table, so r0 can never be forwarded.
  always_comb begin
    new_ent          = '0;
    new_ent.valid    = accept;
    new_ent.idx      = accept ? MAX_REG_W'(dst_reg) : '0;
    new_ent.wait_cnt = (accept && dst_is_load) ? CNT_W'(LOAD_LAT) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ents        <= '0;
      stall_count <= '0;
    end else begin
      ents[0] <= new_ent;
      for (int k = 1; k < FWD_DEPTH; k++) begin
        ents[k].valid    <= ents[k-1].valid;
        ents[k].idx      <= ents[k-1].idx;
        ents[k].wait_cnt <= (ents[k-1].wait_cnt == '0) ? '0
                                                        : ents[k-1].wait_cnt - CNT_W'(1);
      end
      if (stall && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: age-based history model checked every cycle on three
// configurations, plus directed literal checks including a FWD_DEPTH=1 instance.
module tb_id_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic model_live = 1'b0;

  // instance a: defaults
  logic a_valid, a_ready, a_we, a_ld, a_flush, a_stall;
  logic [9:0] a_src; logic [1:0] a_used; logic [4:0] a_dst; logic [3:0] a_sel; logic [15:0] a_cnt;
  // instance b: NUM_SRC=3, FWD_DEPTH=4, LOAD_LAT=2
  logic b_valid, b_ready, b_we, b_ld, b_flush, b_stall;
  logic [14:0] b_src; logic [2:0] b_used; logic [4:0] b_dst; logic [8:0] b_sel; logic [15:0] b_cnt;
  // instance c: NUM_SRC=1, FWD_DEPTH=16, LOAD_LAT=15 (long stall runs)
  logic c_valid, c_ready, c_we, c_ld, c_flush, c_stall;
  logic [4:0] c_src; logic [0:0] c_used; logic [4:0] c_dst; logic [4:0] c_sel; logic [15:0] c_cnt;
  // instance d: NUM_SRC=1, FWD_DEPTH=1, LOAD_LAT=0
  logic d_valid, d_ready, d_we, d_ld, d_flush, d_stall;
  logic [4:0] d_src; logic [0:0] d_used; logic [4:0] d_dst; logic [0:0] d_sel; logic [15:0] d_cnt;

  id_scoreboard u_a (
    .clk(clk), .reset(rst), .issue_valid(a_valid), .issue_ready(a_ready),
    .src_reg(a_src), .src_used(a_used), .dst_reg(a_dst), .dst_we(a_we),
    .dst_is_load(a_ld), .flush(a_flush), .fwd_sel(a_sel), .stall(a_stall),
    .stall_count(a_cnt));

  id_scoreboard #(.NUM_SRC(3), .FWD_DEPTH(4), .LOAD_LAT(2)) u_b (
    .clk(clk), .reset(rst), .issue_valid(b_valid), .issue_ready(b_ready),
    .src_reg(b_src), .src_used(b_used), .dst_reg(b_dst), .dst_we(b_we),
    .dst_is_load(b_ld), .flush(b_flush), .fwd_sel(b_sel), .stall(b_stall),
    .stall_count(b_cnt));

  id_scoreboard #(.NUM_SRC(1), .FWD_DEPTH(16), .LOAD_LAT(15)) u_c (
    .clk(clk), .reset(rst), .issue_valid(c_valid), .issue_ready(c_ready),
    .src_reg(c_src), .src_used(c_used), .dst_reg(c_dst), .dst_we(c_we),
    .dst_is_load(c_ld), .flush(c_flush), .fwd_sel(c_sel), .stall(c_stall),
    .stall_count(c_cnt));

  id_scoreboard #(.NUM_SRC(1), .FWD_DEPTH(1), .LOAD_LAT(0)) u_d (
    .clk(clk), .reset(rst), .issue_valid(d_valid), .issue_ready(d_ready),
    .src_reg(d_src), .src_used(d_used), .dst_reg(d_dst), .dst_we(d_we),
    .dst_is_load(d_ld), .flush(d_flush), .fwd_sel(d_sel), .stall(d_stall),
    .stall_count(d_cnt));

  // packed views shared by the generic model
  logic [2:0][7:0] a_srcs, b_srcs, c_srcs, a_selp, b_selp, c_selp;
  assign a_srcs = {8'd0, {3'd0, a_src[9:5]}, {3'd0, a_src[4:0]}};
  assign b_srcs = {{3'd0, b_src[14:10]}, {3'd0, b_src[9:5]}, {3'd0, b_src[4:0]}};
  assign c_srcs = {8'd0, 8'd0, {3'd0, c_src}};
  assign a_selp = {8'd0, {6'd0, a_sel[3:2]}, {6'd0, a_sel[1:0]}};
  assign b_selp = {{5'd0, b_sel[8:6]}, {5'd0, b_sel[5:3]}, {5'd0, b_sel[2:0]}};
  assign c_selp = {8'd0, 8'd0, {3'd0, c_sel}};

  // history indexed by age: age 1 = accepted last cycle
  logic [16:0] a_hv, b_hv, c_hv, a_hld, b_hld, c_hld;
  logic [16:0][7:0] a_hrd, b_hrd, c_hrd;
  int a_mc, b_mc, c_mc;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // A load accepted a cycles ago has waited a-1 cycles; ready once a-1 >= LOAD_LAT.
  function automatic void mstep(
    input logic [16:0] hv, input logic [16:0][7:0] hrd, input logic [16:0] hld,
    input int depth, input int lat, input int nsrc,
    input logic [2:0][7:0] srcs, input logic [2:0] used, input logic iv, input logic fl,
    output logic [2:0][7:0] esel, output logic [2:0] epend, output logic st);
    logic found;
    esel = '0; epend = '0;
    for (int i = 0; i < nsrc; i++) begin
      found = 1'b0;
      for (int a = 1; a <= depth; a++) begin
        if (!found && used[i] && srcs[i] != 8'd0 && hv[a] && hrd[a] == srcs[i]) begin
          found = 1'b1;
          epend[i] = hld[a] && (a <= lat);
          esel[i]  = epend[i] ? 8'd0 : 8'(a);
        end
      end
    end
    st = iv && !fl && (epend != 3'b000);
  endfunction

  task automatic cmp(input string nm,
    input logic [16:0] hv, input logic [16:0][7:0] hrd, input logic [16:0] hld,
    input int depth, input int lat, input int nsrc,
    input logic [2:0][7:0] srcs, input logic [2:0] used, input logic iv, input logic fl,
    input logic [2:0][7:0] dsel, input logic dstall, input logic dready,
    input int dcnt, input int mcnt);
    logic [2:0][7:0] es; logic [2:0] ep; logic st;
    mstep(hv, hrd, hld, depth, lat, nsrc, srcs, used, iv, fl, es, ep, st);
    chk({nm, ".stall"}, int'(dstall), int'(st));
    chk({nm, ".ready"}, int'(dready), int'(!st));
    for (int i = 0; i < nsrc; i++)
      if (!ep[i]) chk($sformatf("%s.sel%0d", nm, i), int'(dsel[i]), int'(es[i]));
    chk({nm, ".count"}, dcnt, mcnt);
  endtask

  always @(negedge clk) begin
    if (model_live) begin
      cmp("a", a_hv, a_hrd, a_hld, 2, 1, 2, a_srcs, {1'b0, a_used}, a_valid, a_flush,
          a_selp, a_stall, a_ready, int'(a_cnt), a_mc);
      cmp("b", b_hv, b_hrd, b_hld, 4, 2, 3, b_srcs, b_used, b_valid, b_flush,
          b_selp, b_stall, b_ready, int'(b_cnt), b_mc);
      cmp("c", c_hv, c_hrd, c_hld, 16, 15, 1, c_srcs, {2'b00, c_used}, c_valid, c_flush,
          c_selp, c_stall, c_ready, int'(c_cnt), c_mc);
    end
  end

  always @(posedge clk) begin : model_upd
    logic [2:0][7:0] es; logic [2:0] ep; logic st; logic acc;
    if (rst) begin
      a_hv <= '0; a_hrd <= '0; a_hld <= '0; a_mc <= 0;
      b_hv <= '0; b_hrd <= '0; b_hld <= '0; b_mc <= 0;
      c_hv <= '0; c_hrd <= '0; c_hld <= '0; c_mc <= 0;
      model_live <= 1'b1;
    end else begin
      mstep(a_hv, a_hrd, a_hld, 2, 1, 2, a_srcs, {1'b0, a_used}, a_valid, a_flush, es, ep, st);
      acc = a_valid && !st && !a_flush && a_we && a_dst != 5'd0;
      a_hv <= {a_hv[15:1], acc, 1'b0}; a_hld <= {a_hld[15:1], acc && a_ld, 1'b0};
      a_hrd <= {a_hrd[15:1], {3'd0, a_dst}, 8'd0};
      if (st && a_mc < 65535) a_mc <= a_mc + 1;

      mstep(b_hv, b_hrd, b_hld, 4, 2, 3, b_srcs, b_used, b_valid, b_flush, es, ep, st);
      acc = b_valid && !st && !b_flush && b_we && b_dst != 5'd0;
      b_hv <= {b_hv[15:1], acc, 1'b0}; b_hld <= {b_hld[15:1], acc && b_ld, 1'b0};
      b_hrd <= {b_hrd[15:1], {3'd0, b_dst}, 8'd0};
      if (st && b_mc < 65535) b_mc <= b_mc + 1;

      mstep(c_hv, c_hrd, c_hld, 16, 15, 1, c_srcs, {2'b00, c_used}, c_valid, c_flush, es, ep, st);
      acc = c_valid && !st && !c_flush && c_we && c_dst != 5'd0;
      c_hv <= {c_hv[15:1], acc, 1'b0}; c_hld <= {c_hld[15:1], acc && c_ld, 1'b0};
      c_hrd <= {c_hrd[15:1], {3'd0, c_dst}, 8'd0};
      if (st && c_mc < 65535) c_mc <= c_mc + 1;
    end
  end

  task automatic drive_a(input logic v, input int s0, input logic u0, input int s1, input logic u1,
                         input int dst, input logic we, input logic ld, input logic fl);
    @(posedge clk); #1;
    a_valid = v; a_src = {5'(s1), 5'(s0)}; a_used = {u1, u0};
    a_dst = 5'(dst); a_we = we; a_ld = ld; a_flush = fl;
    #2;
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drive_b(input logic v, input int s2, input logic u2, input int dst,
                         input logic we, input logic ld);
    @(posedge clk); #1;
    b_valid = v; b_src = {5'(s2), 10'd0}; b_used = {u2, 2'b00};
    b_dst = 5'(dst); b_we = we; b_ld = ld; b_flush = 1'b0;
    #2;
  endtask

  task automatic drive_d(input logic v, input int s, input logic u, input int dst,
                         input logic we, input logic ld);
    @(posedge clk); #1;
    d_valid = v; d_src = 5'(s); d_used = u; d_dst = 5'(dst); d_we = we; d_ld = ld; d_flush = 1'b0;
    #2;
  endtask

  initial begin
    int ns, cyc;
    rst = 1'b1;
    a_valid = 0; a_src = '0; a_used = '0; a_dst = '0; a_we = 0; a_ld = 0; a_flush = 0;
    b_valid = 0; b_src = '0; b_used = '0; b_dst = '0; b_we = 0; b_ld = 0; b_flush = 0;
    c_valid = 0; c_src = '0; c_used = '0; c_dst = '0; c_we = 0; c_ld = 0; c_flush = 0;
    d_valid = 0; d_src = '0; d_used = '0; d_dst = '0; d_we = 0; d_ld = 0; d_flush = 0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; #2;
    chk("rst.stall", int'(a_stall), 0);
    chk("rst.ready", int'(a_ready), 1);
    chk("rst.count", int'(a_cnt), 0);
    chk("rst.sel",   int'(a_sel), 0);

    // add r3; sub reading r3 -> stage 1; later reader -> stage 2; then retired
    drive_a(1, 0, 0, 0, 0, 3, 1, 0, 0);   chk("add.stall", int'(a_stall), 0);
    drive_a(1, 3, 1, 0, 0, 6, 1, 0, 0);   chk("fwd_ex.sel", int'(a_sel[1:0]), 1);
                                          chk("fwd_ex.stall", int'(a_stall), 0);
    drive_a(1, 0, 0, 3, 1, 0, 0, 0, 0);   chk("fwd_mem.sel", int'(a_sel[3:2]), 2);
    drive_a(1, 0, 0, 3, 1, 0, 0, 0, 0);   chk("retired.sel", int'(a_sel[3:2]), 0);
    idle_a(2);

    // load-use: one stall then forward from stage 2
    drive_a(1, 0, 0, 0, 0, 5, 1, 1, 0);   chk("lw.stall", int'(a_stall), 0);
    drive_a(1, 5, 1, 0, 0, 0, 0, 0, 0);   chk("lu.stall", int'(a_stall), 1);
                                          chk("lu.ready", int'(a_ready), 0);
    drive_a(1, 5, 1, 0, 0, 0, 0, 0, 0);   chk("lu2.sel", int'(a_sel[1:0]), 2);
                                          chk("lu2.stall", int'(a_stall), 0);
                                          chk("lu2.count", int'(a_cnt), 1);
    idle_a(2);

    // youngest pending load beats older ready add
    drive_a(1, 0, 0, 0, 0, 4, 1, 0, 0);
    drive_a(1, 0, 0, 0, 0, 4, 1, 1, 0);
    drive_a(1, 4, 1, 0, 0, 0, 0, 0, 0);   chk("young.stall", int'(a_stall), 1);
    drive_a(1, 4, 1, 0, 0, 0, 0, 0, 0);   chk("young2.sel", int'(a_sel[1:0]), 2);
    idle_a(2);

    // r0 never forwards; unused source ignored; own destination not matched
    drive_a(1, 0, 0, 0, 0, 0, 1, 0, 0);
    drive_a(1, 0, 1, 0, 0, 0, 0, 0, 0);   chk("r0.sel", int'(a_sel), 0);
                                          chk("r0.stall", int'(a_stall), 0);
    drive_a(1, 0, 0, 0, 0, 7, 1, 1, 0);
    drive_a(1, 7, 0, 7, 0, 0, 0, 0, 0);   chk("unused.stall", int'(a_stall), 0);
                                          chk("unused.sel", int'(a_sel), 0);
    idle_a(2);
    drive_a(1, 8, 1, 0, 0, 8, 1, 0, 0);   chk("self.sel", int'(a_sel[1:0]), 0);
    drive_a(1, 0, 0, 8, 1, 0, 0, 0, 0);   chk("self_next.sel", int'(a_sel[3:2]), 1);
    idle_a(2);

    // flush kills the stall and inserts a bubble in place of its r5 write
    drive_a(1, 0, 0, 0, 0, 5, 1, 1, 0);
    drive_a(1, 5, 1, 0, 0, 5, 1, 0, 1);   chk("flush.stall", int'(a_stall), 0);
                                          chk("flush.ready", int'(a_ready), 1);
    drive_a(1, 5, 1, 0, 0, 0, 0, 0, 0);   chk("postflush.sel", int'(a_sel[1:0]), 2);
    idle_a(2);

    // reset during a stall
    drive_a(1, 0, 0, 0, 0, 5, 1, 1, 0);
    drive_a(1, 5, 1, 0, 0, 0, 0, 0, 0);   chk("prerst.stall", int'(a_stall), 1);
                                          chk("prerst.count", int'(a_cnt), 2);
    rst = 1'b1;
    drive_a(1, 5, 1, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    chk("midrst.stall", int'(a_stall), 0);
    chk("midrst.count", int'(a_cnt), 0);
    chk("midrst.sel", int'(a_sel), 0);
    idle_a(1);

    // wide config: two stall cycles then forward from stage 3
    drive_b(1, 0, 0, 9, 1, 1);            chk("b_lw.stall", int'(b_stall), 0);
    drive_b(1, 9, 1, 0, 0, 0);            chk("b_s1.stall", int'(b_stall), 1);
    drive_b(1, 9, 1, 0, 0, 0);            chk("b_s2.stall", int'(b_stall), 1);
    drive_b(1, 9, 1, 0, 0, 0);            chk("b_fwd.sel", int'(b_sel[8:6]), 3);
                                          chk("b_fwd.stall", int'(b_stall), 0);
                                          chk("b_fwd.count", int'(b_cnt), 2);
    drive_b(0, 0, 0, 0, 0, 0);

    // single-stage, zero-latency config: load forwards at once
    drive_d(1, 0, 0, 2, 1, 1);
    drive_d(1, 2, 1, 0, 0, 0);            chk("d_fwd.sel", int'(d_sel), 1);
                                          chk("d_fwd.stall", int'(d_stall), 0);
    drive_d(1, 2, 1, 0, 0, 0);            chk("d_ret.sel", int'(d_sel), 0);
    drive_d(0, 0, 0, 0, 0, 0);

    // saturation: a self-dependent load stalls 15 of every 16 cycles
    @(posedge clk); #1;
    c_valid = 1; c_src = 5'd9; c_used = 1'b1; c_dst = 5'd9; c_we = 1; c_ld = 1;
    ns = 0; cyc = 0;
    while (ns < 65600 && cyc < 80000) begin
      @(posedge clk); #1;
      cyc++;
      if (c_stall) ns++;
    end
    if (ns < 65600) chk("sat.budget", ns, 65600);
    #2;
    chk("sat.count", int'(c_cnt), 65535);
    c_valid = 0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
